uart_report_scheduler: RTL and testbench
========================================

UART_REPORT_SCHEDULER -- requirements
Module: uart_report_scheduler

Interface
REQ-001 SHALL have parameter AUTO_PERIOD_CYC, default 100000000, auto-report interval in clocks (min 2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2000000, max clocks in WAIT_DONE before abort (min 2).
REQ-003 SHALL have parameter GAP_CYC, default 16, idle clocks between reports (min 1).
REQ-004 SHALL have port iClk  in  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port iRstn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports iReqWatchRpt, iReqSr04Rpt, iReqTempRpt, iReqHumRpt  in  1 each  one-cycle report request pulses (sources 0..3).
REQ-007 SHALL have port iAutoEn  in  1  enables periodic auto-report.
REQ-008 SHALL have port iAutoSel  in  2  source index for auto-report.
REQ-009 SHALL have port iSenderBusy  in  1  sender busy level.
REQ-010 SHALL have port iSenderDone  in  1  one-cycle sender completion pulse.
REQ-011 SHALL have port oSendStart  out  1  one-cycle registered start pulse to sender.
REQ-012 SHALL have port oSendSel  out  2  granted source: 00 watch, 01 SR04, 10 temp, 11 hum.
REQ-013 SHALL have port oPending  out  4  pending request bits, bit i = source i.
REQ-014 SHALL have port oBusy  out  1  high in every state except IDLE.
REQ-015 SHALL have port oTimeout  out  1  one-cycle pulse on WAIT_DONE abort.

Function
REQ-016 SHALL latch each request pulse into pending[i] on the sampling edge; repeats while pending coalesce (no count).
REQ-017 SHALL give set priority over grant-clear when a request and the grant of the same source occur on one edge (bit stays 1).
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT_DONE -> GAP -> IDLE.
REQ-019 IDLE: when pending != 0 and iSenderBusy == 0, SHALL select winner, load oSendSel, clear pending[winner], go ISSUE; else stay.
REQ-020 SHALL arbitrate round-robin: search starts at index (last granted + 1) mod 4, ascending with wrap; after reset last granted = 3 (source 0 first).
REQ-021 ISSUE: SHALL assert oSendStart for exactly this one cycle, clear timeout counter, go WAIT_DONE.
REQ-022 WAIT_DONE: on iSenderDone SHALL go GAP; else after TIMEOUT_CYC clocks in state SHALL pulse oTimeout for one cycle and go GAP.
REQ-023 SHALL ignore iSenderDone outside WAIT_DONE.
REQ-024 GAP: SHALL hold GAP_CYC clocks, then go IDLE.
REQ-025 oSendSel SHALL hold its value from ISSUE until the next grant.
REQ-026 Latency: request sampled at edge k -> pending visible after k -> oSendStart high after edge k+2, given IDLE and iSenderBusy = 0.
REQ-027 Auto timer: while iAutoEn = 1, SHALL count 0..AUTO_PERIOD_CYC-1 and wrap; on wrap edge SHALL set pending[iAutoSel].
REQ-028 iAutoEn = 0 SHALL hold the auto counter at 0; re-enable starts a full period.
REQ-029 Requests arriving in any state SHALL be latched and served in later IDLE visits; none are lost.
REQ-030 Counters SHALL be sized to fit ceil(log2(param)) bits with no overflow; no wrap except as specified.

Reset
REQ-031 While iRstn = 0, SHALL force state IDLE, pending 0, last granted 3, all counters 0, oSendStart 0, oSendSel 00, oBusy 0, oTimeout 0.
REQ-032 Reset assertion mid-operation SHALL abort immediately with no further oSendStart; operation resumes on the first edge after iRstn rises.

Verification
REQ-033 Single request: iReqSr04Rpt pulse at edge k, sender idle -> oSendStart after k+2 with oSendSel = 01; iSenderDone -> GAP_CYC clocks -> IDLE, oBusy 0.
REQ-034 Round-robin: all four requests same edge -> grants in order 00, 01, 10, 11, each separated by done + GAP; oPending decrements 1111 -> 1110 -> 1100 -> 1000 -> 0000.
REQ-035 Coalesce/set-wins: iReqTempRpt pulsed 3 times while busy -> exactly one temp report; request on the grant edge of the same source -> bit remains 1, second report issued.
REQ-036 Timeout: grant, no iSenderDone -> oTimeout one pulse exactly TIMEOUT_CYC clocks after entering WAIT_DONE, then GAP, then next pending served.
REQ-037 Auto: AUTO_PERIOD_CYC = 10, iAutoEn = 1, iAutoSel = 11 -> pending[3] set every 10 clocks, reports with oSendSel = 11; iAutoEn low -> no further sets.
REQ-038 Reset mid-WAIT_DONE and iSenderBusy held high in IDLE -> outputs at reset values immediately; no oSendStart while busy high, start follows busy falling.

Source files
------------

// File: rtl/uart_report_scheduler.sv
// uart_report_scheduler: queues report requests from four sources and issues them round-robin to one UART sender
module uart_report_scheduler #(
  parameter int AUTO_PERIOD_CYC = 100000000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int GAP_CYC = 16
) (
  input  logic       iClk,
  input  logic       iRstn,
  input  logic       iReqWatchRpt,
  input  logic       iReqSr04Rpt,
  input  logic       iReqTempRpt,
  input  logic       iReqHumRpt,
  input  logic       iAutoEn,
  input  logic [1:0] iAutoSel,
  input  logic       iSenderBusy,
  input  logic       iSenderDone,
  output logic       oSendStart,
  output logic [1:0] oSendSel,
  output logic [3:0] oPending,
  output logic       oBusy,
  output logic       oTimeout
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2, GAP = 2'd3;
  localparam int AW = $clog2(AUTO_PERIOD_CYC);
  localparam int CMAX = TIMEOUT_CYC > GAP_CYC ? TIMEOUT_CYC : GAP_CYC;
  localparam int CW = $clog2(CMAX);
  logic [1:0] state, lastGnt, winner;
  logic [3:0] pending, reqVec, autoVec, clrVec;
  logic [AW-1:0] autoCnt;
  logic [CW-1:0] cnt;
  logic autoWrap, grant, timeHit, gapHit;
  assign reqVec = {iReqHumRpt, iReqTempRpt, iReqSr04Rpt, iReqWatchRpt};
  assign autoWrap = iAutoEn && autoCnt == AW'(AUTO_PERIOD_CYC - 1);
  assign autoVec = autoWrap ? 4'b0001 << iAutoSel : 4'b0000;
  assign grant = state == IDLE && pending != 4'b0000 && !iSenderBusy;
  assign clrVec = grant ? 4'b0001 << winner : 4'b0000;
  assign timeHit = cnt == CW'(TIMEOUT_CYC - 1);
  assign gapHit = cnt == CW'(GAP_CYC - 1);
  assign oPending = pending;
  assign oBusy = state != IDLE;
  // descending scan so the nearest pending index after lastGnt is written last and wins
  always_comb begin
    winner = lastGnt;
    for (int i = 4; i >= 1; i--)
      if (pending[lastGnt + 2'(i)]) winner = lastGnt + 2'(i);
  end
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state <= IDLE;
      pending <= '0;
      lastGnt <= 2'd3;
      autoCnt <= '0;
      cnt <= '0;
      oSendStart <= 1'b0;
      oSendSel <= 2'b00;
      oTimeout <= 1'b0;
    end else begin
      pending <= (pending & ~clrVec) | reqVec | autoVec;
      autoCnt <= (autoWrap || !iAutoEn) ? '0 : autoCnt + AW'(1);
      oSendStart <= state == ISSUE;
      oTimeout <= state == WAIT_DONE && !iSenderDone && timeHit;
      case (state)
        IDLE: if (grant) begin
          state <= ISSUE;
          oSendSel <= winner;
          lastGnt <= winner;
        end
        ISSUE: begin
          state <= WAIT_DONE;
          cnt <= '0;
        end
        WAIT_DONE: begin
          state <= (iSenderDone || timeHit) ? GAP : WAIT_DONE;
          cnt <= (iSenderDone || timeHit) ? '0 : cnt + CW'(1);
        end
        default: begin
          state <= gapHit ? IDLE : GAP;
          cnt <= gapHit ? '0 : cnt + CW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_report_scheduler.sv
// tb_uart_report_scheduler: directed checks of grant order, latency, coalescing, timeout, auto-report and reset
module tb_uart_report_scheduler;
  logic iClk = 1'b0, iRstn = 1'b0;
  logic iReqWatchRpt = 1'b0, iReqSr04Rpt = 1'b0, iReqTempRpt = 1'b0, iReqHumRpt = 1'b0;
  logic iAutoEn = 1'b0, iSenderBusy = 1'b0, iSenderDone = 1'b0;
  logic [1:0] iAutoSel = 2'b00;
  logic oSendStart, oBusy, oTimeout;
  logic [1:0] oSendSel;
  logic [3:0] oPending;
  int nAsserts = 0, nFails = 0;

  uart_report_scheduler #(.AUTO_PERIOD_CYC(10), .TIMEOUT_CYC(8), .GAP_CYC(3)) dut (
    .iClk(iClk), .iRstn(iRstn),
    .iReqWatchRpt(iReqWatchRpt), .iReqSr04Rpt(iReqSr04Rpt),
    .iReqTempRpt(iReqTempRpt), .iReqHumRpt(iReqHumRpt),
    .iAutoEn(iAutoEn), .iAutoSel(iAutoSel),
    .iSenderBusy(iSenderBusy), .iSenderDone(iSenderDone),
    .oSendStart(oSendStart), .oSendSel(oSendSel), .oPending(oPending),
    .oBusy(oBusy), .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic setReq(input logic [3:0] r);
    {iReqHumRpt, iReqTempRpt, iReqSr04Rpt, iReqWatchRpt} = r;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_start"}, oSendStart, 0);
    chk({tag, "_sel"}, oSendSel, 0);
    chk({tag, "_pend"}, oPending, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_tmo"}, oTimeout, 0);
  endtask

  // starts from IDLE with pending work: grant edge, start pulse, done, full gap back to IDLE
  task automatic grantAndFinish(input string tag, input logic [1:0] sel, input logic [3:0] pendAfter,
                                input logic [3:0] reqOnGrant);
    setReq(reqOnGrant);
    tick;
    setReq(4'b0000);
    chk({tag, "_pendAfterGrant"}, oPending, pendAfter);
    chk({tag, "_busyIssue"}, oBusy, 1);
    chk({tag, "_noStartYet"}, oSendStart, 0);
    tick;
    chk({tag, "_start"}, oSendStart, 1);
    chk({tag, "_sel"}, oSendSel, sel);
    iSenderDone = 1'b1;
    tick;
    iSenderDone = 1'b0;
    chk({tag, "_startOnce"}, oSendStart, 0);
    chk({tag, "_busyGap"}, oBusy, 1);
    chk({tag, "_noTmo"}, oTimeout, 0);
    tick;
    tick;
    chk({tag, "_gapHeld"}, oBusy, 1);
    chk({tag, "_selHeld"}, oSendSel, sel);
    tick;
    chk({tag, "_idle"}, oBusy, 0);
  endtask

  initial begin
    tick;
    tick;
    checkResetOutputs("rst");
    iRstn = 1'b1;
    tick;
    checkResetOutputs("postRst");

    // single SR04 request: pending after k, start after k+2, gap of 3 clocks
    setReq(4'b0010);
    tick;
    setReq(4'b0000);
    chk("sr04_pend", oPending, 4'b0010);
    chk("sr04_idleBusy", oBusy, 0);
    grantAndFinish("sr04", 2'b01, 4'b0000, 4'b0000);

    // fresh reset so round-robin starts at source 0
    iRstn = 1'b0;
    tick;
    iRstn = 1'b1;
    tick;
    setReq(4'b1111);
    tick;
    setReq(4'b0000);
    chk("rr_pendAll", oPending, 4'b1111);
    grantAndFinish("rr0", 2'b00, 4'b1110, 4'b0000);
    grantAndFinish("rr1", 2'b01, 4'b1100, 4'b0000);
    grantAndFinish("rr2", 2'b10, 4'b1000, 4'b0000);
    grantAndFinish("rr3", 2'b11, 4'b0000, 4'b0000);

    // coalesce three temp pulses arriving while a watch report is in flight
    setReq(4'b0001);
    tick;
    setReq(4'b0000);
    tick;
    tick;
    chk("coal_start", oSendStart, 1);
    chk("coal_sel", oSendSel, 2'b00);
    for (int n = 0; n < 3; n++) begin
      iReqTempRpt = 1'b1;
      tick;
      iReqTempRpt = 1'b0;
      tick;
    end
    chk("coal_pend", oPending, 4'b0100);
    iSenderDone = 1'b1;
    tick;
    iSenderDone = 1'b0;
    tick;
    tick;
    tick;
    chk("coal_idle", oBusy, 0);
    grantAndFinish("setWins", 2'b10, 4'b0100, 4'b0100);
    grantAndFinish("second", 2'b10, 4'b0000, 4'b0000);
    tick;
    chk("coal_drained", oPending, 4'b0000);
    chk("coal_staysIdle", oBusy, 0);

    // timeout: hum granted, no done; watch queued meanwhile is served afterwards
    setReq(4'b1000);
    tick;
    setReq(4'b0000);
    tick;
    tick;
    chk("tmo_start", oSendStart, 1);
    chk("tmo_sel", oSendSel, 2'b11);
    iReqWatchRpt = 1'b1;
    tick;
    iReqWatchRpt = 1'b0;
    for (int n = 0; n < 6; n++) tick;
    chk("tmo_notYet", oTimeout, 0);
    chk("tmo_waiting", oBusy, 1);
    tick;
    chk("tmo_pulse", oTimeout, 1);
    iSenderDone = 1'b1;
    tick;
    iSenderDone = 1'b0;
    chk("tmo_onePulse", oTimeout, 0);
    chk("tmo_gap", oBusy, 1);
    tick;
    chk("tmo_gapIgnoresDone", oBusy, 1);
    tick;
    chk("tmo_idle", oBusy, 0);
    chk("tmo_pendWatch", oPending, 4'b0001);
    grantAndFinish("tmoNext", 2'b00, 4'b0000, 4'b0000);

    // auto-report every 10 clocks on source 3
    iAutoSel = 2'b11;
    iAutoEn = 1'b1;
    for (int n = 0; n < 9; n++) tick;
    chk("auto_notYet", oPending, 4'b0000);
    tick;
    chk("auto_set1", oPending, 4'b1000);
    grantAndFinish("auto1", 2'b11, 4'b0000, 4'b0000);
    tick;
    tick;
    tick;
    chk("auto_between", oPending, 4'b0000);
    tick;
    chk("auto_set2", oPending, 4'b1000);
    iAutoEn = 1'b0;
    grantAndFinish("auto2", 2'b11, 4'b0000, 4'b0000);
    for (int n = 0; n < 15; n++) tick;
    chk("auto_off_pend", oPending, 4'b0000);
    chk("auto_off_busy", oBusy, 0);

    // reset in WAIT_DONE, then sender busy blocks the next grant
    setReq(4'b0010);
    tick;
    setReq(4'b0000);
    tick;
    tick;
    tick;
    chk("rstMid_waiting", oBusy, 1);
    iRstn = 1'b0;
    #1;
    checkResetOutputs("rstMid");
    tick;
    checkResetOutputs("rstHeld");
    iSenderBusy = 1'b1;
    iRstn = 1'b1;
    setReq(4'b0001);
    tick;
    setReq(4'b0000);
    chk("busy_pend", oPending, 4'b0001);
    tick;
    tick;
    tick;
    chk("busy_noStart", oSendStart, 0);
    chk("busy_idle", oBusy, 0);
    chk("busy_pendHeld", oPending, 4'b0001);
    iSenderBusy = 1'b0;
    grantAndFinish("afterBusy", 2'b00, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
